// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM states,
// the RX FIFO entry layout and the expected-parity helper.
package uart_pkg;

    localparam logic [1:0] PAR_SPACE = 2'b00;
    localparam logic [1:0] PAR_MARK  = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_ODD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAITHI
    } rx_state_t;

    typedef struct packed {
        logic       brk;
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    // Parity bit the transmitter should have sent for this data and mode.
    // Unused data MSBs are zero, so they never disturb the reduction.
    function automatic logic expected_parity(input logic [1:0] mode, input logic [7:0] data);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Ready/valid stream carrying received characters and their error flags.
interface uart_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_parity_err;
    logic       m_frame_err;
    logic       m_break;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_parity_err,
        output m_frame_err,
        output m_break,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_parity_err,
        input  m_frame_err,
        input  m_break,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with level, full and empty flags.
// A push on a full FIFO is accepted only when a pop frees a slot in the same
// cycle; the head output is forced to zero while the FIFO is empty.
module uart_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Decide which requests actually take effect this cycle and present the head.
    always_comb begin
        empty    = (count == '0);
        full     = (count == (AW+1)'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = empty ? '0 : mem[rd_ptr];
        level    = count;
    end

    // Storage array; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled majority voting, configurable framing and an
// RX FIFO presented as a ready/valid stream with a sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    data_bits,
    input  logic                          parity_en,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bit_size,
    uart_rx_fifo_if.master                m,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE/2);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE/2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    rx_state_t        state;
    logic [SW-1:0]    s_cnt;
    logic [1:0]       samp;
    logic [2:0]       bit_cnt;
    logic [7:0]       data_reg;
    logic [1:0]       nbits_l;
    logic             par_en_l;
    logic [1:0]       par_mode_l;
    logic             stop2_l;
    logic             stop_idx;
    logic             par_vote;
    logic             frame_err_r;
    logic             parity_err_r;

    logic             start_det;
    logic             at_vote;
    logic             at_end;
    logic             vote;
    logic             last_bit;
    logic             last_stop;
    logic             stop_fe;
    logic             push;
    rx_entry_t        push_entry;
    rx_entry_t        head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Per-cycle decode: tick, vote timing, majority vote and the entry to push.
    always_comb begin
        tick      = (tick_cnt == baud_div);
        start_det = (state == ST_IDLE) && !rx_sync;
        at_vote   = tick && (s_cnt == S_V2);
        at_end    = tick && (s_cnt == S_LAST);
        vote      = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
        last_bit  = (bit_cnt == {1'b1, nbits_l});
        last_stop = !stop2_l || stop_idx;
        stop_fe   = frame_err_r | ~vote;
        push      = (state == ST_STOP) && at_vote && last_stop;

        push_entry            = '0;
        push_entry.data       = data_reg;
        push_entry.parity_err = parity_err_r;
        push_entry.frame_err  = stop_fe;
        push_entry.brk        = (data_reg == 8'h00) && !(par_en_l && par_vote) && stop_fe;
    end

    // Free-running sample tick divider, realigned to the falling start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (start_det || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // Hold the first two of the three mid-bit samples for the majority vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= 2'b11;
        end else if (tick && (s_cnt == S_V0)) begin
            samp[0] <= rx_sync;
        end else if (tick && (s_cnt == S_V1)) begin
            samp[1] <= rx_sync;
        end
    end

    // Receive state machine: framing, bit assembly, error flags and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            s_cnt        <= '0;
            bit_cnt      <= '0;
            data_reg     <= '0;
            nbits_l      <= '0;
            par_en_l     <= 1'b0;
            par_mode_l   <= '0;
            stop2_l      <= 1'b0;
            stop_idx     <= 1'b0;
            par_vote     <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (tick && (state != ST_IDLE) && (state != ST_WAITHI)) begin
                s_cnt <= at_end ? '0 : s_cnt + SW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state        <= ST_START;
                        s_cnt        <= '0;
                        bit_cnt      <= '0;
                        data_reg     <= '0;
                        nbits_l      <= data_bits;
                        par_en_l     <= parity_en;
                        par_mode_l   <= parity_mode;
                        stop2_l      <= stop_bit_size;
                        stop_idx     <= 1'b0;
                        par_vote     <= 1'b0;
                        frame_err_r  <= 1'b0;
                        parity_err_r <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ST_START: begin
                    if (at_vote && vote) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (at_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (at_vote) begin
                        data_reg[bit_cnt] <= vote;
                    end
                    if (at_end) begin
                        if (last_bit) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_vote) begin
                        par_vote     <= vote;
                        parity_err_r <= (vote != expected_parity(par_mode_l, data_reg));
                    end
                    if (at_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (at_vote) begin
                        if (last_stop) begin
                            state <= stop_fe ? ST_WAITHI : ST_IDLE;
                            busy  <= stop_fe;
                            s_cnt <= '0;
                        end else begin
                            frame_err_r <= stop_fe;
                        end
                    end
                    if (at_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                ST_WAITHI: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: a character arrived while the FIFO had no free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign pop            = m.m_ready && !fifo_empty;
    assign m.m_valid      = !fifo_empty;
    assign m.m_data       = head.data;
    assign m.m_parity_err = head.parity_err;
    assign m.m_frame_err  = head.frame_err;
    assign m.m_break      = head.brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised, scoreboarded bench for uart_rx_fifo. Frames are built from a
// character and framing options; the expected entry is derived from framing
// rules and queued, and a monitor compares every entry the DUT hands over.
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [15:0] baud_div;
    logic [1:0] data_bits;
    logic       parity_en;
    logic [1:0] parity_mode;
    logic       stop_bit_size;
    logic       overrun_clr;
    logic       overrun;
    logic [4:0] fifo_level;
    logic       busy;
    logic       m_ready_drv = 1'b0;
    int         ready_ctl = 0;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rise_cyc = -1;
    int         last_start = 0;
    logic       prev_valid = 1'b0;
    logic [10:0] exp_q [$];

    uart_rx_fifo_if sif ();
    assign sif.m_ready = m_ready_drv;

    uart_rx_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .baud_div      (baud_div),
        .data_bits     (data_bits),
        .parity_en     (parity_en),
        .parity_mode   (parity_mode),
        .stop_bit_size (stop_bit_size),
        .m             (sif),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .fifo_level    (fifo_level),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time the arrival of entries.
    always @(posedge clk) cyc <= cyc + 1;

    // Drive m_ready just after each edge: held low, held high or random.
    always @(posedge clk) begin
        #1;
        case (ready_ctl)
            0:       m_ready_drv = 1'b0;
            1:       m_ready_drv = 1'b1;
            default: m_ready_drv = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Record the cycle at which m_valid first rises.
    always @(negedge clk) begin
        if (sif.m_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = sif.m_valid;
    end

    // Scoreboard monitor: every accepted entry must match the queue head.
    always @(negedge clk) begin
        if (!rst && sif.m_valid && sif.m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_entry: got %0h expected none",
                         {sif.m_break, sif.m_frame_err, sif.m_parity_err, sif.m_data});
            end else begin
                checkOutput("entry", 32'({sif.m_break, sif.m_frame_err, sif.m_parity_err, sif.m_data}),
                            32'(exp_q.pop_front()));
            end
        end
    end

    task automatic holdClks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one frame and queue the entry the receiver should produce.
    task automatic applyStimulus(input logic [7:0] ch, input logic [1:0] nb, input logic pen,
                                 input logic [1:0] pmode, input logic st2, input logic bad_par,
                                 input logic stop_val, input int extra_low, input bit store);
        int         n;
        int         ones;
        logic [7:0] d;
        logic       exp_par;
        logic       sent_par;
        logic       pe;
        logic       fe;
        logic       brk;
        n = 5 + int'(nb);
        d = ch & 8'((1 << n) - 1);
        ones = $countones(d);
        case (pmode)
            2'b11:   exp_par = (ones % 2 == 0);
            2'b10:   exp_par = (ones % 2 == 1);
            2'b01:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
        sent_par = exp_par ^ bad_par;
        pe  = pen && (sent_par != exp_par);
        fe  = (stop_val == 1'b0);
        brk = (d == 8'h00) && (!pen || !sent_par) && fe;
        if (store) exp_q.push_back({brk, fe, pe, d});

        data_bits     = nb;
        parity_en     = pen;
        parity_mode   = pmode;
        stop_bit_size = st2;
        @(posedge clk);
        #1;
        rx = 1'b0;
        last_start = cyc;
        holdClks(BIT_CLKS);
        for (int i = 0; i < n; i++) begin
            rx = d[i];
            holdClks(BIT_CLKS);
        end
        if (pen) begin
            rx = sent_par;
            holdClks(BIT_CLKS);
        end
        for (int i = 0; i < (st2 ? 2 : 1); i++) begin
            rx = stop_val;
            holdClks(BIT_CLKS);
        end
        if (extra_low > 0) begin
            rx = 1'b0;
            holdClks(extra_low);
        end
        rx = 1'b1;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Hard stop if something hangs.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        rx = 1'b1;
        rst = 1'b1;
        baud_div = 16'd3;
        data_bits = 2'b11;
        parity_en = 1'b0;
        parity_mode = 2'b00;
        stop_bit_size = 1'b0;
        overrun_clr = 1'b0;
        holdClks(4);
        checkOutput("rst_valid", 32'(sif.m_valid), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_data", 32'(sif.m_data), 32'd0);
        rst = 1'b0;
        holdClks(10);

        // 8N1 0xA5 held in the FIFO, then drained.
        $display("[TB] 8N1 0xA5");
        applyStimulus(8'hA5, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        holdClks(2);
        lat = rise_cyc - last_start;
        checkOutput("a5_valid", 32'(sif.m_valid), 32'd1);
        checkOutput("a5_level", 32'(fifo_level), 32'd1);
        checkOutput("a5_latency_in_stop_bit",
                    32'(lat >= 9*BIT_CLKS + 35 && lat <= 9*BIT_CLKS + 51), 32'd1);
        ready_ctl = 1;
        waitDrain("a5_drain");
        checkOutput("a5_level_after", 32'(fifo_level), 32'd0);

        // 7E2 0x35 with a wrong parity bit.
        $display("[TB] 7E2 parity error");
        applyStimulus(8'h35, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 0, 1'b1);
        holdClks(20);
        waitDrain("par_drain");

        // 5-bit 0x1F with a low stop bit, line then held low.
        $display("[TB] 5-bit frame error");
        applyStimulus(8'h1F, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 200, 1'b1);
        holdClks(20);
        waitDrain("fe_drain");
        checkOutput("fe_level", 32'(fifo_level), 32'd0);
        checkOutput("fe_busy_idle", 32'(busy), 32'd0);

        // Long low line: a break.
        $display("[TB] break");
        applyStimulus(8'h00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 200, 1'b1);
        holdClks(20);
        waitDrain("brk_drain");
        checkOutput("brk_level", 32'(fifo_level), 32'd0);

        // Short glitch on an idle line.
        $display("[TB] glitch");
        rx = 1'b0;
        holdClks(3);
        rx = 1'b1;
        n = 0;
        while (!busy && n < 10) begin holdClks(1); n++; end
        checkOutput("glitch_busy_rise", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 200) begin holdClks(1); n++; end
        checkOutput("glitch_busy_fall", 32'(busy), 32'd0);
        holdClks(100);
        checkOutput("glitch_level", 32'(fifo_level), 32'd0);

        // Overflow: 17 characters into a 16-deep FIFO with the sink stalled.
        $display("[TB] overrun");
        ready_ctl = 0;
        holdClks(2);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'($urandom), 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, (i < 16));
            holdClks(10);
        end
        checkOutput("ovr_level", 32'(fifo_level), 32'd16);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        holdClks(1);
        overrun_clr = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun), 32'd0);
        ready_ctl = 1;
        waitDrain("ovr_drain");
        checkOutput("ovr_level_after", 32'(fifo_level), 32'd0);

        // Random framing, data and parity errors with a random sink.
        $display("[TB] random frames");
        ready_ctl = 2;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                          1'($urandom), ($urandom_range(0, 3) == 0), 1'b1, 0, 1'b1);
            holdClks($urandom_range(10, 100));
        end
        waitDrain("rand_drain");
        ready_ctl = 1;
        holdClks(5);
        checkOutput("rand_level", 32'(fifo_level), 32'd0);
        checkOutput("rand_valid", 32'(sif.m_valid), 32'd0);
        checkOutput("final_overrun", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
